// File: rtl/display_source_sequencer_pkg.sv
// Shared constants for the display source sequencer.
// Mode encodings and the board-clock dwell default.
package display_source_sequencer_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // One second of dwell at the 50 MHz board clock
    localparam int DWELL_DEFAULT = 50_000_000;

endpackage

// File: rtl/display_source_sequencer_if.sv
// Channel bundle, control inputs and registered outputs
// of the display source sequencer.
interface display_source_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) ();

    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic                     mode;
    logic [SEL_W-1:0]         manual_sel;
    logic                     freeze;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic [SEL_W-1:0]         active_ch;
    logic                     ch_changed;

    modport master (
        output ch_data, ch_valid, mode, manual_sel, freeze,
        input  out_data, out_valid, active_ch, ch_changed
    );

    modport slave (
        input  ch_data, ch_valid, mode, manual_sel, freeze,
        output out_data, out_valid, active_ch, ch_changed
    );

endinterface

// File: rtl/display_source_sequencer_next_valid_channel.sv
// Round-robin search for the next valid channel after cur_ch,
// never returning cur_ch itself.
module next_valid_channel #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] ch_valid,
    input  logic [SEL_W-1:0]  cur_ch,
    output logic              found,
    output logic [SEL_W-1:0]  nxt_ch
);

    int idx;

    // Walk farthest to nearest so the closest valid channel wins
    always_comb begin
        found  = 1'b0;
        nxt_ch = cur_ch;
        idx    = 0;
        for (int k = NUM_CH - 1; k >= 1; k--) begin
            idx = (int'(cur_ch) + k) % NUM_CH;
            if (ch_valid[idx]) begin
                found  = 1'b1;
                nxt_ch = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/display_source_sequencer.sv
// N-channel source selector for the hex display and buzzer:
// manual pick or dwell-timed round-robin scan, registered outputs.
module display_source_sequencer
    import display_source_sequencer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 8,
    parameter int DWELL_CYCLES = DWELL_DEFAULT,
    parameter int SEL_W        = $clog2(NUM_CH)
) (
    input logic clk,
    input logic reset,
    display_source_sequencer_if.slave bus
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [SEL_W-1:0]  active_ch;
    logic [SEL_W-1:0]  next_ch;
    logic [SEL_W-1:0]  scan_ch;
    logic              scan_found;
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;

    next_valid_channel #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_search (
        .ch_valid (bus.ch_valid),
        .cur_ch   (active_ch),
        .found    (scan_found),
        .nxt_ch   (scan_ch)
    );

    always_comb begin
        next_ch = active_ch;
        cnt_nxt = cnt;
        if (bus.mode == MODE_MANUAL) begin
            cnt_nxt = '0;
            if (int'(bus.manual_sel) < NUM_CH) begin
                next_ch = bus.manual_sel;
            end
        end else if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (scan_found) begin
                next_ch = scan_ch;
            end
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (next_ch == SEL_W'(i)) begin
                sel_data  = bus.ch_data[i*DATA_W +: DATA_W];
                sel_valid = bus.ch_valid[i];
            end
        end
    end

    // Invalid selection keeps the last good word on the display
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            active_ch      <= '0;
            bus.out_data   <= '0;
            bus.out_valid  <= 1'b0;
            bus.ch_changed <= 1'b0;
        end else if (bus.freeze) begin
            bus.ch_changed <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            active_ch      <= next_ch;
            bus.out_valid  <= sel_valid;
            bus.ch_changed <= (next_ch != active_ch);
            if (sel_valid) begin
                bus.out_data <= sel_data;
            end
        end
    end

    assign bus.active_ch = active_ch;

endmodule

// File: tb/tb_display_source_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed expectations,
// monitors compare after each clock edge and on async reset.
module tb_display_source_sequencer;

    typedef struct {
        string      tag;
        bit         d3;
        logic [1:0] ch;
        logic [7:0] d;
        logic       v;
        logic       c;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad = 0;

    exp_t q[$];
    exp_t rq[$];

    display_source_sequencer_if #(.NUM_CH(4), .DATA_W(8)) b4 ();
    display_source_sequencer_if #(.NUM_CH(3), .DATA_W(8)) b3 ();

    display_source_sequencer #(
        .NUM_CH(4), .DATA_W(8), .DWELL_CYCLES(4)
    ) u4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    display_source_sequencer #(
        .NUM_CH(3), .DATA_W(8), .DWELL_CYCLES(4)
    ) u3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
    );

    always #5 clk = ~clk;

    task automatic cmp(input exp_t e);
        logic [1:0] ch;
        logic [7:0] d;
        logic v;
        logic c;
        if (e.d3) begin
            ch = b3.active_ch; d = b3.out_data;
            v = b3.out_valid;  c = b3.ch_changed;
        end else begin
            ch = b4.active_ch; d = b4.out_data;
            v = b4.out_valid;  c = b4.ch_changed;
        end
        total++;
        if (ch !== e.ch || d !== e.d || v !== e.v || c !== e.c) begin
            bad++;
            $display("FAIL %s: got ch=%0d data=%h vld=%b chg=%b want ch=%0d data=%h vld=%b chg=%b",
                     e.tag, ch, d, v, c, e.ch, e.d, e.v, e.c);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge reset);
            #1;
            if (rq.size() > 0) begin
                e = rq.pop_front();
                cmp(e);
            end
        end
    end

    task automatic step(input string tag, input bit d3, input int ch,
                        input logic [7:0] d, input bit v, input bit c);
        exp_t e;
        e.tag = tag; e.d3 = d3; e.ch = 2'(ch);
        e.d = d; e.v = v; e.c = c;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t r;
        logic [7:0] wd [4];
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;

        b4.ch_data = {8'h44, 8'h33, 8'h22, 8'h11};
        b4.ch_valid = 4'b1111;
        b4.mode = 1'b0;
        b4.manual_sel = 2'd0;
        b4.freeze = 1'b0;
        b3.ch_data = {8'hC3, 8'hB2, 8'hA1};
        b3.ch_valid = 3'b111;
        b3.mode = 1'b0;
        b3.manual_sel = 2'd0;
        b3.freeze = 1'b0;

        step("reset_state", 0, 0, 8'h00, 0, 0);
        reset = 1'b0;
        step("manual_ch0", 0, 0, 8'h11, 1, 0);

        b4.manual_sel = 2'd2;
        step("sel2_pulse", 0, 2, 8'h33, 1, 1);
        step("sel2_nopulse", 0, 2, 8'h33, 1, 0);
        step("sel2_again", 0, 2, 8'h33, 1, 0);

        b3.manual_sel = 2'd1;
        step("n3_sel1", 1, 1, 8'hB2, 1, 1);
        b3.manual_sel = 2'd3;
        step("n3_oor_a", 1, 1, 8'hB2, 1, 0);
        step("n3_oor_b", 1, 1, 8'hB2, 1, 0);

        r.tag = "async_reset"; r.d3 = 0; r.ch = 2'd0;
        r.d = 8'h00; r.v = 1'b0; r.c = 1'b0;
        rq.push_back(r);
        #2 reset = 1'b1;
        @(negedge clk);
        b4.manual_sel = 2'd0;
        reset = 1'b0;
        step("post_reset", 0, 0, 8'h11, 1, 0);
        step("n3_oor_after_rst", 1, 0, 8'hA1, 1, 0);

        b4.mode = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            for (int h = 0; h < 3; h++)
                step("scan_hold", 0, (s - 1) % 4, wd[(s - 1) % 4], 1, 0);
            step("scan_step", 0, s % 4, wd[s % 4], 1, 1);
        end

        b4.ch_valid = 4'b1001;
        for (int h = 0; h < 3; h++) step("skip_hold0", 0, 0, 8'h11, 1, 0);
        step("skip_to3", 0, 3, 8'h44, 1, 1);
        for (int h = 0; h < 3; h++) step("skip_hold3", 0, 3, 8'h44, 1, 0);
        step("wrap_to0", 0, 0, 8'h11, 1, 1);

        b4.ch_valid = 4'b0001;
        for (int h = 0; h < 4; h++) step("alone_stay", 0, 0, 8'h11, 1, 0);
        b4.ch_valid = 4'b1111;
        for (int h = 0; h < 3; h++) step("alone_wrapped", 0, 0, 8'h11, 1, 0);
        step("after_wrap_to1", 0, 1, 8'h22, 1, 1);

        step("pre_freeze_a", 0, 1, 8'h22, 1, 0);
        step("pre_freeze_b", 0, 1, 8'h22, 1, 0);
        b4.freeze = 1'b1;
        b4.ch_data[15:8] = 8'h99;
        for (int h = 0; h < 10; h++) step("frozen", 0, 1, 8'h22, 1, 0);
        b4.freeze = 1'b0;
        step("thaw_hold", 0, 1, 8'h99, 1, 0);
        step("thaw_advance", 0, 2, 8'h33, 1, 1);

        b4.mode = 1'b0;
        b4.manual_sel = 2'd1;
        b4.ch_valid = 4'b1101;
        step("man_invalid", 0, 1, 8'h33, 0, 1);
        step("man_invalid_hold", 0, 1, 8'h33, 0, 0);
        b4.ch_valid = 4'b1111;
        b4.ch_data[15:8] = 8'h5A;
        step("man_revalid", 0, 1, 8'h5A, 1, 0);

        b4.mode = 1'b1;
        for (int h = 0; h < 3; h++) step("reauto_hold", 0, 1, 8'h5A, 1, 0);
        step("reauto_step", 0, 2, 8'h33, 1, 1);

        @(negedge clk);
        total++;
        if (q.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending=%0d want pending=0",
                     q.size() + rq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
